// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Load-use stall, redirect flush, memory freeze and forwarding select
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int AW        = 5,
  parameter int NSRC      = 2,
  parameter int NFWD      = 2,
  parameter int LU_CYCLES = 1,
  localparam int FW       = $clog2(NFWD + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_req,
  input  logic               branch_flush,
  input  logic               jump_flush,
  input  logic [NSRC*AW-1:0] id_rsel,
  input  logic [NSRC-1:0]    id_uses,
  input  logic [NSRC*AW-1:0] ex_rsel,
  input  logic               ex_load,
  input  logic [AW-1:0]      ex_wsel,
  input  logic [NFWD-1:0]    wr_en,
  input  logic [NFWD*AW-1:0] wr_sel,
  output logic [NSRC*FW-1:0] fwd_sel,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_flush,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               lu_busy,
  output logic [15:0]        stall_cycles
);

  localparam logic [2:0] CNT_INIT = 3'(LU_CYCLES - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t     state;
  state_t     run_state;
  logic [2:0] cnt;
  logic       memwait;
  logic       adv;
  logic       redirect;
  logic       hz;

  assign memwait  = mem_req & ~dhit;
  assign adv      = ihit & ~memwait;
  assign redirect = branch_flush | jump_flush;
  assign lu_busy  = (state == LU_STALL);

  // While reset is asserted the outputs behave as if already back in RUN.
  assign run_state = nRST ? state : RUN;

  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_uses[i] && (id_rsel[i*AW +: AW] == ex_wsel)) hz = 1'b1;
    end
    hz = hz & ex_load & (ex_wsel != '0);
  end

  // Scan from the farthest stage down so the nearest matching writer wins.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (wr_en[j] && (wr_sel[j*AW +: AW] != '0) &&
            (wr_sel[j*AW +: AW] == ex_rsel[i*AW +: AW]))
          fwd_sel[i*FW +: FW] = FW'(j + 1);
      end
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = adv;
    memwb_en   = adv;
    if (adv) begin
      if (redirect) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
      end else if (run_state == LU_STALL || hz) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= RUN;
      cnt          <= 3'd0;
      stall_cycles <= 16'd0;
    end else if (!memwait) begin
      if (!pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (adv) begin
        case (state)
          RUN: begin
            if (!redirect && hz && LU_CYCLES > 1) begin
              state <= LU_STALL;
              cnt   <= CNT_INIT;
            end
          end
          LU_STALL: begin
            if (redirect || cnt == 3'd1) begin
              state <= RUN;
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          default: begin
            state <= RUN;
            cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench, LU_CYCLES=1 and LU_CYCLES=3 instances
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int NSRC = 2;
  localparam int NFWD = 2;
  localparam int FW = 2;

  logic               CLK = 1'b0;
  logic               nRST, ihit, dhit, mem_req, branch_flush, jump_flush;
  logic [NSRC*AW-1:0] id_rsel, ex_rsel;
  logic [NSRC-1:0]    id_uses;
  logic               ex_load;
  logic [AW-1:0]      ex_wsel;
  logic [NFWD-1:0]    wr_en;
  logic [NFWD*AW-1:0] wr_sel;

  logic [NSRC*FW-1:0] fwd1, fwd3;
  logic pc1, ifen1, iffl1, iden1, idfl1, exen1, mwen1, busy1;
  logic pc3, ifen3, iffl3, iden3, idfl3, exen3, mwen3, busy3;
  logic [15:0] stc1, stc3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .NFWD(NFWD), .LU_CYCLES(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .branch_flush(branch_flush), .jump_flush(jump_flush),
    .id_rsel(id_rsel), .id_uses(id_uses), .ex_rsel(ex_rsel),
    .ex_load(ex_load), .ex_wsel(ex_wsel), .wr_en(wr_en), .wr_sel(wr_sel),
    .fwd_sel(fwd1), .pc_en(pc1), .ifid_en(ifen1), .ifid_flush(iffl1),
    .idex_en(iden1), .idex_flush(idfl1), .exmem_en(exen1), .memwb_en(mwen1),
    .lu_busy(busy1), .stall_cycles(stc1)
  );

  pipeline_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .NFWD(NFWD), .LU_CYCLES(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .branch_flush(branch_flush), .jump_flush(jump_flush),
    .id_rsel(id_rsel), .id_uses(id_uses), .ex_rsel(ex_rsel),
    .ex_load(ex_load), .ex_wsel(ex_wsel), .wr_en(wr_en), .wr_sel(wr_sel),
    .fwd_sel(fwd3), .pc_en(pc3), .ifid_en(ifen3), .ifid_flush(iffl3),
    .idex_en(iden3), .idex_flush(idfl3), .exmem_en(exen3), .memwb_en(mwen3),
    .lu_busy(busy3), .stall_cycles(stc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0;
    branch_flush = 1'b0; jump_flush = 1'b0;
    id_rsel = '0; id_uses = '0; ex_rsel = '0; ex_load = 1'b0; ex_wsel = 5'd3;
    wr_en = '0; wr_sel = '0;
    tick; tick;
    #1;
    chk("reset_pc_en_run_fn", {31'd0, pc3}, 32'd1);
    chk("reset_busy", {31'd0, busy3}, 32'd0);
    chk("reset_stall_cnt", {16'd0, stc3}, 32'd0);
    nRST = 1'b1;
    tick;

    // Normal flow and instruction-miss behaviour
    id_rsel = {5'd0, 5'd3}; id_uses = 2'b00; ex_load = 1'b1;
    #1;
    chk("no_use_no_hz", {29'd0, pc3, iden3, idfl3}, 32'b110);
    id_uses = 2'b01; ex_wsel = 5'd0; id_rsel = {5'd0, 5'd0};
    #1;
    chk("wsel0_no_hz", {31'd0, pc3}, 32'd1);
    ex_load = 1'b0; ex_wsel = 5'd3; id_rsel = {5'd0, 5'd3};
    ihit = 1'b0;
    #1;
    chk("imiss_enables", {27'd0, pc3, ifen3, iden3, exen3, mwen3}, 32'd0);
    tick;
    chk("imiss_counts", {16'd0, stc3}, 32'd1);
    ihit = 1'b1;
    nRST = 1'b0;
    tick;
    nRST = 1'b1;

    // Load-use bubble: one cycle for LU_CYCLES=1, three for LU_CYCLES=3
    ex_load = 1'b1;
    #1;
    chk("lu1_bubble", {27'd0, pc1, ifen1, iden1, idfl1, iffl1}, 32'b00110);
    chk("lu3_bubble1", {28'd0, pc3, busy3, idfl3, iffl3}, 32'b0010);
    tick;
    ex_load = 1'b0;
    #1;
    chk("lu1_resume", {31'd0, pc1}, 32'd1);
    chk("lu1_stall_cnt", {16'd0, stc1}, 32'd1);
    chk("lu3_bubble2", {29'd0, pc3, busy3, idfl3}, 32'b011);
    tick;
    #1;
    chk("lu3_bubble3", {29'd0, pc3, busy3, idfl3}, 32'b011);
    tick;
    #1;
    chk("lu3_resume", {29'd0, pc3, busy3, idfl3}, 32'b100);
    chk("lu3_stall_cnt", {16'd0, stc3}, 32'd3);

    // Redirect beats a load-use hazard in RUN
    ex_load = 1'b1; branch_flush = 1'b1;
    #1;
    chk("redir_hz_outs", {28'd0, pc3, ifen3, iffl3, idfl3}, 32'b1111);
    tick;
    chk("redir_hz_state", {31'd0, busy3}, 32'd0);
    branch_flush = 1'b0;

    // Memory freeze in the middle of a load-use stall
    tick;
    ex_load = 1'b0; mem_req = 1'b1; dhit = 1'b0;
    #1;
    chk("freeze_busy", {31'd0, busy3}, 32'd1);
    chk("freeze_outs", {25'd0, pc3, ifen3, iffl3, iden3, idfl3, exen3, mwen3}, 32'd0);
    repeat (4) tick;
    chk("freeze_held_busy", {31'd0, busy3}, 32'd1);
    chk("freeze_held_cnt", {16'd0, stc3}, 32'd4);
    mem_req = 1'b0; dhit = 1'b1;
    #1;
    chk("resume_bubble2", {29'd0, pc3, busy3, idfl3}, 32'b011);
    tick;
    chk("resume_bubble3", {30'd0, pc3, busy3}, 32'b01);
    tick;
    chk("resume_done", {30'd0, pc3, busy3}, 32'b10);
    chk("resume_stall_cnt", {16'd0, stc3}, 32'd6);

    // Jump redirect inside LU_STALL leaves immediately
    ex_load = 1'b1;
    tick;
    ex_load = 1'b0; jump_flush = 1'b1;
    #1;
    chk("stall_redir_outs", {28'd0, pc3, ifen3, iffl3, idfl3}, 32'b1111);
    tick;
    chk("stall_redir_state", {31'd0, busy3}, 32'd0);
    jump_flush = 1'b0;

    // Forwarding select priority
    wr_en = 2'b11; wr_sel = {5'd5, 5'd5}; ex_rsel = {5'd5, 5'd0};
    #1;
    chk("fwd_nearest", {28'd0, fwd3}, 32'b0100);
    wr_sel = {5'd5, 5'd0};
    #1;
    chk("fwd_far", {28'd0, fwd3}, 32'b1000);
    wr_en = 2'b00;
    #1;
    chk("fwd_none", {28'd0, fwd1}, 32'b0000);
    wr_en = 2'b10; wr_sel = {5'd7, 5'd9}; ex_rsel = {5'd9, 5'd7};
    #1;
    chk("fwd_src0", {28'd0, fwd1}, 32'b0010);
    wr_en = 2'b00;

    // Reset in the middle of a stall
    ex_load = 1'b1;
    tick;
    ex_load = 1'b0; nRST = 1'b0;
    #1;
    chk("rst_in_stall_runfn", {31'd0, pc3}, 32'd1);
    tick;
    nRST = 1'b1;
    chk("rst_in_stall_busy", {31'd0, busy3}, 32'd0);
    chk("rst_in_stall_cnt", {16'd0, stc3}, 32'd0);

    // Saturation of the stall counter
    ihit = 1'b0;
    repeat (65540) @(posedge CLK);
    #1;
    chk("sat_reach", {16'd0, stc3}, 32'h0000FFFF);
    tick;
    chk("sat_hold", {16'd0, stc3}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, number of source operands checked per instruction (index 0 = Rs, 1 = Rt).
REQ-003 SHALL have parameter NFWD, default 2, number of downstream writer stages; index 0 = nearest (EX/MEM), highest priority.
REQ-004 SHALL have parameter LU_CYCLES, default 1, range 1-7, number of bubbles inserted per load-use hazard; FW = $clog2(NFWD+1).
REQ-005 SHALL have ports:
  CLK  in  1  clock; one clock only.
  nRST  in  1  reset, synchronous, active-low.
  ihit, dhit  in  1 each  instruction/data cache hit.
  mem_req  in  1  MEM stage holds LW or SW.
  branch_flush, jump_flush  in  1 each  control-transfer redirect.
  id_rsel  in  NSRC*AW  ID-stage source registers; id_uses in NSRC marks each as read.
  ex_rsel  in  NSRC*AW  EX-stage source registers.
  ex_load  in  1  EX holds a load; ex_wsel in AW is its destination.
  wr_en  in  NFWD  per-stage register-write enables; wr_sel in NFWD*AW are their destinations.
  fwd_sel  out  NSRC*FW  per-operand forward select (0 = register file, j+1 = stage j).
  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en  out  1 each  pipeline control.
  lu_busy  out  1  high in LU_STALL state.
  stall_cycles  out  16  saturating count of cycles with pc_en low.

Function
REQ-006 SHALL define memwait = mem_req & !dhit and adv = ihit & !memwait.
REQ-007 SHALL, when memwait is high, drive all enables and flushes low (full freeze) and hold state and counter unchanged.
REQ-008 SHALL define hz = ex_load & ex_wsel != 0 & OR over i of (id_uses[i] & id_rsel[i] == ex_wsel).
REQ-009 SHALL define redirect = branch_flush | jump_flush.
REQ-010 SHALL, in RUN with adv and redirect, drive pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; redirect overrides hz, with no stall and no state change.
REQ-011 SHALL, in RUN with adv, hz and no redirect, drive pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (first bubble).
REQ-012 SHALL, on the REQ-011 condition, go to LU_STALL with cnt=LU_CYCLES-1 if LU_CYCLES>1, else remain in RUN.
REQ-013 SHALL, in RUN with adv, no hz and no redirect, drive pc_en, ifid_en and idex_en high and both flushes low.
REQ-014 SHALL, in LU_STALL with adv, drive pc_en=0, ifid_en=0, idex_flush=1 and decrement cnt, returning to RUN on the cycle cnt==1.
REQ-015 SHALL, on a redirect in LU_STALL with adv, apply the REQ-010 outputs and return to RUN immediately.
REQ-016 SHALL drive exmem_en = memwb_en = ihit & !memwait in every state; with !ihit and !memwait, pc_en/ifid_en/idex_en are 0 and state holds.
REQ-017 SHALL set fwd_sel[i] = j+1 for the lowest j with wr_en[j] & wr_sel[j] != 0 & wr_sel[j] == ex_rsel[i], else 0; fwd_sel is combinational and independent of state.
REQ-018 SHALL increment stall_cycles every cycle pc_en==0, saturating at 16'hFFFF with no wrap.

Reset
REQ-019 SHALL, on a rising CLK with nRST==0, set state=RUN, cnt=0 and stall_cycles=0, regardless of memwait or an in-progress stall.
REQ-020 SHALL keep combinational outputs as the RUN-state function of inputs while in reset; lu_busy=0 after the reset edge.

Verification
REQ-021 SHALL cover: ex_load=1, ex_wsel=3, id_rsel[0]=3, id_uses=01, ihit=1 with LU_CYCLES=1 -> one cycle pc_en=0, idex_flush=1, then pc_en=1; stall_cycles=1.
REQ-022 SHALL cover: same stimulus with LU_CYCLES=3 -> three consecutive bubble cycles, lu_busy high for cycles 2-3, stall_cycles=3.
REQ-023 SHALL cover: hz and branch_flush in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, state stays RUN.
REQ-024 SHALL cover: mem_req=1, dhit=0 for 4 cycles mid LU_STALL -> all enables 0, cnt frozen; the stall resumes after dhit=1.
REQ-025 SHALL cover: wr_en=11, wr_sel={5,5}, ex_rsel[1]=5 -> fwd_sel[1]=1; wr_sel[0]=0 -> fwd_sel[1]=2.
REQ-026 SHALL cover: nRST low during LU_STALL -> RUN and stall_cycles=0 next cycle; forced 16'hFFFF plus stall -> value holds.
